// File: rtl/xbar_sched_if.sv
// Handshake bundle between the input queues, the crossbar scheduler and the output queues.
// The master side drives the queue heads and the downstream ready bits.
interface xbar_sched_if #(
    parameter int PKT_W = 32
);
    logic                  en;
    logic [3:0][PKT_W-1:0] in_pkt;
    logic [3:0]            in_avail;
    logic [3:0]            in_pop;
    logic [3:0][PKT_W-1:0] out_pkt;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic                  drop;
    logic [15:0]           stall_cnt;

    modport master (
        output en, in_pkt, in_avail, out_ready,
        input  in_pop, out_pkt, out_valid, drop, stall_cnt
    );

    modport slave (
        input  en, in_pkt, in_avail, out_ready,
        output in_pop, out_pkt, out_valid, drop, stall_cnt
    );
endinterface

// File: rtl/xbar_sched.sv
// Round-robin packet scheduler for a 4x4 router crossbar with one holding register per output port.
// A packet is granted only when its output stage is free or draining this cycle, so a blocked port never stalls the others.
module xbar_sched #(
    parameter int ROUTERID = 0
) (
    input logic         clk,
    input logic         rst_b,
    xbar_sched_if.slave bus
);

    logic [3:0][1:0] dest_port;
    logic [3:0]      dest_ok;
    logic [3:0]      can_take;
    logic [3:0]      elig;
    logic            grant_vld;
    logic [1:0]      grant_idx;
    logic [1:0]      scan_idx;
    logic [1:0]      rr_ptr;
    logic [2:0]      route_res;

    // Returns {valid, port}; destinations on the far router leave through port 3.
    function automatic logic [2:0] route(input logic [3:0] d);
        if (d > 4'd5)
            return 3'b000;
        if (ROUTERID == 0)
            return (d < 4'd3) ? {1'b1, d[1:0]} : 3'b111;
        return (d >= 4'd3) ? {1'b1, 2'(d - 4'd3)} : 3'b111;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dest_port = '0;
        dest_ok   = '0;
        elig      = '0;
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        scan_idx  = rr_ptr;
        route_res = '0;
        can_take  = ~bus.out_valid | bus.out_ready;

        for (int i = 0; i < 4; i++) begin
            route_res    = route(bus.in_pkt[i][27:24]);
            dest_ok[i]   = route_res[2];
            dest_port[i] = route_res[1:0];
            elig[i]      = bus.en & bus.in_avail[i] & (~dest_ok[i] | can_take[dest_port[i]]);
        end

        // Scan from the farthest offset down so the nearest eligible input after rr_ptr wins.
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_ptr + k[1:0];
            if (elig[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end

        bus.in_pop = (grant_vld && rst_b) ? (4'b0001 << grant_idx) : 4'b0000;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            // NOTE: the packet registers are reset too, so out_pkt reads zero after reset rather than stale data.
            bus.out_pkt   <= '0;
            bus.out_valid <= '0;
            bus.drop      <= 1'b0;
            bus.stall_cnt <= '0;
            rr_ptr        <= '0;
        end else begin
            bus.drop <= grant_vld & ~dest_ok[grant_idx];

            if (grant_vld)
                rr_ptr <= grant_idx + 2'd1;
            else if (bus.en && (bus.in_avail != 4'b0000) && (bus.stall_cnt != 16'hFFFF))
                bus.stall_cnt <= bus.stall_cnt + 16'd1;

            for (int p = 0; p < 4; p++) begin
                if (grant_vld && dest_ok[grant_idx] && (dest_port[grant_idx] == 2'(p))) begin
                    bus.out_pkt[p]   <= bus.in_pkt[grant_idx];
                    bus.out_valid[p] <= 1'b1;
                end else if (bus.out_ready[p]) begin
                    bus.out_valid[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xbar_sched.sv
// Directed bench for xbar_sched: a ROUTERID=0 instance checked through a per-port scoreboard,
// plus a ROUTERID=1 instance for the cross-port bypass case.
module tb_xbar_sched;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    xbar_sched_if #(.PKT_W(32)) bus0 ();
    xbar_sched_if #(.PKT_W(32)) bus1 ();

    xbar_sched #(.ROUTERID(0)) dut0 (.clk(clk), .rst_b(rst_b), .bus(bus0));
    xbar_sched #(.ROUTERID(1)) dut1 (.clk(clk), .rst_b(rst_b), .bus(bus1));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [4][$];
    logic [31:0] mon_exp;
    int          grant_cnt [4];
    logic [3:0]  exp_pop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference router: {valid, port} for a packet's destination field.
    function automatic logic [2:0] model_route(input logic [31:0] pkt, input int rid);
        logic [3:0] d;
        d = pkt[27:24];
        case (d)
            4'd0, 4'd1, 4'd2: return (rid == 0) ? {1'b1, d[1:0]} : 3'b111;
            4'd3:             return (rid == 0) ? 3'b111 : 3'b100;
            4'd4:             return (rid == 0) ? 3'b111 : 3'b101;
            4'd5:             return (rid == 0) ? 3'b111 : 3'b110;
            default:          return 3'b000;
        endcase
    endfunction

    task automatic expect_grant0(input int g);
        logic [2:0]  r;
        logic [31:0] pkt;
        exp_pop = 4'b0001 << g;
        check($sformatf("in_pop_g%0d", g), 64'(bus0.in_pop), 64'(exp_pop));
        pkt = bus0.in_pkt[g];
        r   = model_route(pkt, 0);
        if (r[2])
            exp_q[r[1:0]].push_back(pkt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every transfer on a port must match the oldest packet granted to it.
    always @(negedge clk) begin
        if (rst_b) begin
            for (int p = 0; p < 4; p++) begin
                if (bus0.out_valid[p] && bus0.out_ready[p]) begin
                    check($sformatf("sb_pending_p%0d", p), 64'(exp_q[p].size() != 0), 64'd1);
                    if (exp_q[p].size() != 0) begin
                        mon_exp = exp_q[p].pop_front();
                        check($sformatf("sb_pkt_p%0d", p), 64'(bus0.out_pkt[p]), 64'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b          = 1'b0;
        bus0.en        = 1'b1;
        bus0.in_avail  = 4'hF;
        bus0.in_pkt    = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
        bus0.out_ready = 4'hF;
        bus1.en        = 1'b1;
        bus1.in_avail  = 4'h0;
        bus1.in_pkt    = '0;
        bus1.out_ready = 4'hF;

        // Reset state, with inputs available to show in_pop is held off.
        #12;
        check("rst_in_pop", 64'(bus0.in_pop), 64'h0);
        check("rst_out_valid", 64'(bus0.out_valid), 64'h0);
        check("rst_drop", 64'(bus0.drop), 64'h0);
        check("rst_stall", 64'(bus0.stall_cnt), 64'h0);
        check("rst_out_pkt2", 64'(bus0.out_pkt[2]), 64'h0);
        bus0.in_avail = 4'h0;
        @(negedge clk);
        rst_b = 1'b1;
        tick();

        // Single packet to port 2, one-cycle latency.
        bus0.in_pkt[0] = 32'h0200_00AA;
        bus0.in_avail  = 4'b0001;
        #1;
        expect_grant0(0);
        tick();
        bus0.in_avail = 4'b0000;
        #1;
        check("single_valid", 64'(bus0.out_valid), 64'b0100);
        check("single_pkt", 64'(bus0.out_pkt[2]), 64'h0200_00AA);
        tick();
        check("single_clear", 64'(bus0.out_valid), 64'h0);
        check("single_stall", 64'(bus0.stall_cnt), 64'h0);

        // Round robin: pointer sits at 1 after the previous grant.
        bus0.in_avail = 4'hF;
        for (int k = 0; k < 16; k++) begin
            bus0.in_pkt[0] = {4'h0, 4'h0, 8'(k), 16'h0000};
            bus0.in_pkt[1] = {4'h1, 4'h1, 8'(k), 16'h1111};
            bus0.in_pkt[2] = {4'h2, 4'h2, 8'(k), 16'h2222};
            bus0.in_pkt[3] = {4'h3, 4'h4, 8'(k), 16'h3333};
            #1;
            expect_grant0((1 + k) % 4);
            for (int i = 0; i < 4; i++)
                if (bus0.in_pop[i]) grant_cnt[i]++;
            tick();
        end
        bus0.in_avail = 4'h0;
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_count_%0d", i), 64'(grant_cnt[i]), 64'd4);
        tick();
        tick();

        // Backpressure on port 1: one grant, then four stalled cycles.
        bus0.out_ready = 4'b1101;
        bus0.in_pkt[0] = 32'h0100_0A01;
        bus0.in_avail  = 4'b0001;
        #1;
        expect_grant0(0);
        tick();
        bus0.in_pkt[0] = 32'h0100_0A02;
        for (int s = 0; s < 4; s++) begin
            #1;
            check("bp_pop", 64'(bus0.in_pop), 64'h0);
            check("bp_valid1", 64'(bus0.out_valid[1]), 64'h1);
            check("bp_hold", 64'(bus0.out_pkt[1]), 64'h0100_0A01);
            tick();
        end
        #1;
        check("bp_stall", 64'(bus0.stall_cnt), 64'd4);
        bus0.out_ready = 4'hF;
        #1;
        expect_grant0(0);
        tick();
        bus0.in_pkt[0] = 32'h0100_0A03;
        #1;
        check("bp_next_valid", 64'(bus0.out_valid[1]), 64'h1);
        check("bp_next_pkt", 64'(bus0.out_pkt[1]), 64'h0100_0A02);
        expect_grant0(0);
        tick();
        bus0.in_avail = 4'h0;
        #1;
        check("bp_last_valid", 64'(bus0.out_valid[1]), 64'h1);
        check("bp_last_pkt", 64'(bus0.out_pkt[1]), 64'h0100_0A03);
        tick();
        check("bp_empty", 64'(bus0.out_valid), 64'h0);
        check("bp_stall_hold", 64'(bus0.stall_cnt), 64'd4);

        // Invalid destination on input 2.
        bus0.in_pkt[2] = 32'h2F00_1234;
        bus0.in_avail  = 4'b0100;
        #1;
        expect_grant0(2);
        check("inv_drop_pre", 64'(bus0.drop), 64'h0);
        tick();
        bus0.in_avail = 4'h0;
        #1;
        check("inv_drop", 64'(bus0.drop), 64'h1);
        check("inv_no_valid", 64'(bus0.out_valid), 64'h0);
        tick();
        check("inv_drop_clear", 64'(bus0.drop), 64'h0);
        check("inv_stall", 64'(bus0.stall_cnt), 64'd4);

        // ROUTERID=1: blocked port 1 must not hold back input 1 headed for port 3.
        bus1.out_ready = 4'b1101;
        bus1.in_pkt[3] = 32'h3400_0003;
        bus1.in_avail  = 4'b1000;
        #1;
        check("hol_fill_pop", 64'(bus1.in_pop), 64'b1000);
        tick();
        bus1.in_pkt[0] = 32'h0400_0001;
        bus1.in_pkt[1] = 32'h1000_0002;
        bus1.in_avail  = 4'b0011;
        #1;
        check("hol_fill_valid", 64'(bus1.out_valid), 64'b0010);
        check("hol_fill_pkt", 64'(bus1.out_pkt[1]), 64'h3400_0003);
        check("hol_bypass_pop", 64'(bus1.in_pop), 64'b0010);
        tick();
        bus1.in_avail = 4'b0001;
        #1;
        check("hol_valid", 64'(bus1.out_valid), 64'b1010);
        check("hol_p3_pkt", 64'(bus1.out_pkt[3]), 64'h1000_0002);
        check("hol_pending_pop", 64'(bus1.in_pop), 64'h0);
        tick();
        check("hol_p3_drained", 64'(bus1.out_valid), 64'b0010);
        check("hol_still_pending", 64'(bus1.in_pop), 64'h0);
        check("hol_p1_hold", 64'(bus1.out_pkt[1]), 64'h3400_0003);
        bus1.out_ready = 4'hF;
        #1;
        check("hol_release_pop", 64'(bus1.in_pop), 64'b0001);
        tick();
        bus1.in_avail = 4'h0;
        #1;
        check("hol_release_pkt", 64'(bus1.out_pkt[1]), 64'h0400_0001);
        check("hol_release_valid", 64'(bus1.out_valid), 64'b0010);
        tick();

        // Asynchronous reset with ports 1 and 3 loaded; pointer sits at 3 beforehand.
        bus0.out_ready = 4'b0101;
        bus0.in_pkt[1] = 32'h1100_0B01;
        bus0.in_pkt[3] = 32'h3300_0B03;
        bus0.in_avail  = 4'b1010;
        #1;
        expect_grant0(3);
        tick();
        bus0.in_avail = 4'b0010;
        #1;
        expect_grant0(1);
        tick();
        bus0.in_avail = 4'h0;
        #1;
        check("ar_loaded", 64'(bus0.out_valid), 64'b1010);
        check("ar_stall_pre", 64'(bus0.stall_cnt), 64'd4);
        #1;
        bus0.in_pkt = {32'h3300_0C03, 32'h2200_0C02, 32'h1100_0C01, 32'h0000_0C00};
        bus0.in_avail  = 4'hF;
        bus0.out_ready = 4'hF;
        rst_b = 1'b0;
        #1;
        check("ar_valid", 64'(bus0.out_valid), 64'h0);
        check("ar_stall", 64'(bus0.stall_cnt), 64'h0);
        check("ar_drop", 64'(bus0.drop), 64'h0);
        check("ar_pop", 64'(bus0.in_pop), 64'h0);
        for (int p = 0; p < 4; p++)
            exp_q[p].delete();
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        expect_grant0(0);
        tick();
        bus0.in_avail = 4'h0;
        tick();
        tick();

        for (int p = 0; p < 4; p++)
            check($sformatf("sb_drained_p%0d", p), 64'(exp_q[p].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
